address_stepper: RTL

- Parametrised, registered successor to the CPU's combinational 16-bit increment/decrement unit.
- Holds an address register that can be loaded, single-stepped up or down, or run as a length-counted burst with a start/busy/done handshake.
- Used as the address generator for the PC/SP step path and for DMA-style block transfers (OAM DMA, HDMA source/destination).

---
 rtl/address_stepper_if.sv | 32 +++
 rtl/address_stepper.sv | 122 ++++++++++++
 2 files changed

// File: rtl/address_stepper_if.sv
// Bus bundle between an address_stepper and its consumer: load/burst
// control in, address and handshake status out.
interface address_stepper_if #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned LEN_WIDTH = 8
) ();

  logic                 i_Load;
  logic [WIDTH-1:0]     i_LoadValue;
  logic                 i_Start;
  logic [LEN_WIDTH-1:0] i_Length;
  logic                 i_Decrement;
  logic                 i_Step;
  logic [WIDTH-1:0]     o_Addr;
  logic                 o_Valid;
  logic                 o_Busy;
  logic                 o_Done;
  logic                 o_Carry;

  // Consumer side: issues commands, observes address and status.
  modport master (
    output i_Load, i_LoadValue, i_Start, i_Length, i_Decrement, i_Step,
    input  o_Addr, o_Valid, o_Busy, o_Done, o_Carry
  );

  // Stepper side.
  modport slave (
    input  i_Load, i_LoadValue, i_Start, i_Length, i_Decrement, i_Step,
    output o_Addr, o_Valid, o_Busy, o_Done, o_Carry
  );

endinterface

// File: rtl/address_stepper.sv
// Registered address generator: load, single step +/-1, or length-counted
// burst with start/busy/done handshake. Wraps modulo 2^WIDTH.
module address_stepper #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned LEN_WIDTH = 8
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  address_stepper_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic [WIDTH-1:0]     r_addr;
  logic [LEN_WIDTH-1:0] r_count;
  logic                 r_dir;
  logic                 r_carry;
  logic                 r_valid;
  logic                 r_busy;
  logic                 r_done;

  state_t               w_state_nxt;
  logic [WIDTH-1:0]     w_addr_nxt;
  logic [LEN_WIDTH-1:0] w_count_nxt;
  logic                 w_dir_nxt;
  logic                 w_carry_nxt;

  logic                 w_step_dec;
  logic [WIDTH-1:0]     w_addr_inc;
  logic [WIDTH-1:0]     w_addr_dec;
  logic [WIDTH-1:0]     w_addr_stepped;
  logic                 w_wrap;

  // Single steps use the live direction; bursts use the one latched at start.
  assign w_step_dec     = (r_state == S_RUN) ? r_dir : bus.i_Decrement;
  assign w_addr_inc     = r_addr + WIDTH'(1);
  assign w_addr_dec     = r_addr - WIDTH'(1);
  assign w_addr_stepped = w_step_dec ? w_addr_dec : w_addr_inc;
  assign w_wrap         = w_step_dec ? (r_addr == '0) : (&r_addr);

  // State register plus all registered outputs.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_count <= '0;
      r_dir   <= 1'b0;
      r_carry <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_count <= w_count_nxt;
      r_dir   <= w_dir_nxt;
      r_carry <= w_carry_nxt;
      r_valid <= (w_state_nxt == S_RUN);
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= (w_state_nxt == S_DONE);
    end
  end

  // Next-state and datapath update.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_count_nxt = r_count;
    w_dir_nxt   = r_dir;
    w_carry_nxt = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (bus.i_Load) begin
          w_addr_nxt = bus.i_LoadValue;
        end else if (bus.i_Start) begin
          if (bus.i_Length != '0) begin
            w_count_nxt = bus.i_Length;
            w_dir_nxt   = bus.i_Decrement;
            w_state_nxt = S_RUN;
          end else begin
            w_state_nxt = S_DONE;
          end
        end else if (bus.i_Step) begin
          w_addr_nxt  = w_addr_stepped;
          w_carry_nxt = w_wrap;
        end
      end

      S_RUN: begin
        if (bus.i_Step) begin
          w_addr_nxt  = w_addr_stepped;
          w_carry_nxt = w_wrap;
          w_count_nxt = r_count - LEN_WIDTH'(1);
          if (r_count == LEN_WIDTH'(1)) begin
            w_state_nxt = S_DONE;
          end
        end
      end

      S_DONE: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.o_Addr  = r_addr;
  assign bus.o_Valid = r_valid;
  assign bus.o_Busy  = r_busy;
  assign bus.o_Done  = r_done;
  assign bus.o_Carry = r_carry;

endmodule
